// File: rtl/ct_f_spsram_4096x144_req_ctrl.sv
// Request front-end for the 4096x144 single-port SRAM: valid/ready requests in,
// active-low CEN/GWEN/WEN out, read data returned through a 2-entry response FIFO.
module ct_f_spsram_4096x144_req_ctrl #(
   parameter int unsigned ADDR_WIDTH = 12,
   parameter int unsigned DATA_WIDTH = 144,
   parameter bit          INIT_EN    = 1'b1
) (
   input  logic                  forever_cpuclk,
   input  logic                  cpurst_b,
   input  logic                  req_vld,
   output logic                  req_rdy,
   input  logic                  req_wr,
   input  logic [ADDR_WIDTH-1:0] req_addr,
   input  logic [DATA_WIDTH-1:0] req_wdata,
   input  logic [DATA_WIDTH-1:0] req_wmask,
   output logic                  rsp_vld,
   input  logic                  rsp_rdy,
   output logic [DATA_WIDTH-1:0] rsp_data,
   output logic                  init_done,
   output logic [ADDR_WIDTH-1:0] sram_a,
   output logic                  sram_cen,
   output logic                  sram_gwen,
   output logic [DATA_WIDTH-1:0] sram_wen,
   output logic [DATA_WIDTH-1:0] sram_d,
   input  logic [DATA_WIDTH-1:0] sram_q
);

   localparam logic [1:0] RST_WAIT = 2'd0;
   localparam logic [1:0] INIT     = 2'd1;
   localparam logic [1:0] RUN      = 2'd2;

   logic [1:0]            state;
   logic [1:0]            state_nxt;
   logic [ADDR_WIDTH-1:0] init_cnt;
   logic [1:0]            occ;
   logic [1:0]            occ_nxt;
   logic [1:0]            credit_used;
   logic                  inflt;
   logic [DATA_WIDTH-1:0] tail;
   logic                  accept;
   logic                  rd_acc;
   logic                  push;
   logic                  pop;

   assign pop         = rsp_vld & rsp_rdy;
   assign push        = inflt;
   // Slots committed for the next cycle: held entries plus the read landing now, minus the one leaving.
   assign credit_used = occ + {1'b0, inflt} - {1'b0, pop};
   assign req_rdy     = (state == RUN) && (credit_used < 2'd2);
   assign accept      = req_vld & req_rdy;
   assign rd_acc      = accept & ~req_wr;
   assign occ_nxt     = occ + {1'b0, push} - {1'b0, pop};

   // Next-state logic
   always_comb begin
      state_nxt = state;
      case (state)
         RST_WAIT: state_nxt = INIT_EN ? INIT : RUN;
         INIT:     if (init_cnt == '1) state_nxt = RUN;
         RUN:      state_nxt = RUN;
         default:  state_nxt = RST_WAIT;
      endcase
   end

   // SRAM pin drive: fill pattern during INIT, accepted request in RUN, idle otherwise
   always_comb begin
      sram_cen  = 1'b1;
      sram_gwen = 1'b1;
      sram_wen  = '1;
      sram_a    = req_addr;
      sram_d    = req_wdata;
      if (state == INIT) begin
         sram_cen  = 1'b0;
         sram_gwen = 1'b0;
         sram_wen  = '0;
         sram_a    = init_cnt;
         sram_d    = '0;
      end else if (accept) begin
         sram_cen = 1'b0;
         if (req_wr) begin
            sram_gwen = 1'b0;
            sram_wen  = ~req_wmask;
         end
      end
   end

   always_ff @(posedge forever_cpuclk or negedge cpurst_b) begin
      if (!cpurst_b) begin
         state     <= RST_WAIT;
         init_cnt  <= '0;
         init_done <= 1'b0;
         inflt     <= 1'b0;
      end else begin
         state     <= state_nxt;
         init_cnt  <= (state == INIT) ? init_cnt + ADDR_WIDTH'(1) : '0;
         init_done <= (state_nxt == RUN);
         inflt     <= rd_acc;
      end
   end

   // Response FIFO: rsp_data is the head register, tail holds the second entry
   always_ff @(posedge forever_cpuclk or negedge cpurst_b) begin
      if (!cpurst_b) begin
         occ      <= 2'd0;
         rsp_vld  <= 1'b0;
         rsp_data <= '0;
         tail     <= '0;
      end else begin
         occ     <= occ_nxt;
         rsp_vld <= (occ_nxt != 2'd0);
         case ({push, pop})
            2'b11: begin
               if (occ == 2'd1) begin
                  rsp_data <= sram_q;
               end else begin
                  rsp_data <= tail;
                  tail     <= sram_q;
               end
            end
            2'b10: begin
               if (occ == 2'd0) rsp_data <= sram_q;
               else             tail     <= sram_q;
            end
            2'b01:   rsp_data <= tail;
            default: ;
         endcase
      end
   end

endmodule

// File: tb/tb_ct_f_spsram_4096x144_req_ctrl.sv
// Directed self-checking bench for ct_f_spsram_4096x144_req_ctrl with a behavioural SRAM.
module tb_ct_f_spsram_4096x144_req_ctrl;

   logic          clk;
   logic          rst_n;
   logic          req_vld;
   logic          req_rdy;
   logic          req_wr;
   logic [11:0]   req_addr;
   logic [143:0]  req_wdata;
   logic [143:0]  req_wmask;
   logic          rsp_vld;
   logic          rsp_rdy;
   logic [143:0]  rsp_data;
   logic          init_done;
   logic [11:0]   sram_a;
   logic          sram_cen;
   logic          sram_gwen;
   logic [143:0]  sram_wen;
   logic [143:0]  sram_d;
   logic [143:0]  sram_q;

   logic [143:0]  mem [4096];
   int            n_cmp = 0;
   int            n_err = 0;

   localparam logic [143:0] ONES  = {144{1'b1}};
   localparam logic [143:0] PAT5A = {18{8'h5A}};
   localparam logic [143:0] HALF  = {{72{1'b1}}, 72'h0};

   ct_f_spsram_4096x144_req_ctrl dut (
      .forever_cpuclk(clk),
      .cpurst_b      (rst_n),
      .req_vld       (req_vld),
      .req_rdy       (req_rdy),
      .req_wr        (req_wr),
      .req_addr      (req_addr),
      .req_wdata     (req_wdata),
      .req_wmask     (req_wmask),
      .rsp_vld       (rsp_vld),
      .rsp_rdy       (rsp_rdy),
      .rsp_data      (rsp_data),
      .init_done     (init_done),
      .sram_a        (sram_a),
      .sram_cen      (sram_cen),
      .sram_gwen     (sram_gwen),
      .sram_wen      (sram_wen),
      .sram_d        (sram_d),
      .sram_q        (sram_q)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Behavioural single-port SRAM, active-low controls, one-cycle read latency
   always @(posedge clk) begin
      if (!sram_cen) begin
         if (!sram_gwen) mem[sram_a] <= (mem[sram_a] & sram_wen) | (sram_d & ~sram_wen);
         else            sram_q <= mem[sram_a];
      end
   end

   task automatic chk(input string tag, input logic [143:0] obs, input logic [143:0] exp);
      n_cmp++;
      assert (obs === exp) else begin
         n_err++;
         $error("FAIL %s: observed %h expected %h", tag, obs, exp);
      end
   endtask

   // Called at a negedge; issues one request and returns at the negedge after acceptance.
   task automatic send(input logic wr, input logic [11:0] addr, input logic [143:0] data,
                       input logic [143:0] mask);
      int n;
      n = 0;
      req_vld = 1'b1; req_wr = wr; req_addr = addr; req_wdata = data; req_wmask = mask;
      #1;
      while (req_rdy !== 1'b1 && n < 50) begin
         @(negedge clk); #1; n++;
      end
      chk("send_rdy", {143'h0, req_rdy}, 144'h1);
      @(posedge clk); #1;
      req_vld = 1'b0;
      @(negedge clk);
   endtask

   // Read addr and check the N+1 / N+2 response timing and data.
   task automatic read_chk(input string tag, input logic [11:0] addr, input logic [143:0] exp);
      send(1'b0, addr, '0, '0);
      #1 chk({tag, "_n1_vld"}, {143'h0, rsp_vld}, 144'h0);
      @(negedge clk); #1;
      chk({tag, "_n2_vld"}, {143'h0, rsp_vld}, 144'h1);
      chk({tag, "_n2_data"}, rsp_data, exp);
      @(negedge clk);
   endtask

   // Called at a negedge with rst_n low: releases reset and checks the full zero-fill.
   task automatic init_run();
      int err;
      int nwr;
      err = 0; nwr = 0;
      req_vld = 1'b1; req_wr = 1'b1; req_addr = 12'hFFF; req_wdata = ONES; req_wmask = ONES;
      rst_n = 1'b1;
      #1;
      chk("rstwait_cen", {143'h0, sram_cen}, 144'h1);
      chk("rstwait_rdy", {143'h0, req_rdy}, 144'h0);
      for (int i = 0; i < 4096; i++) begin
         @(negedge clk); #1;
         if (sram_cen === 1'b0 && sram_gwen === 1'b0) nwr++;
         if (sram_cen !== 1'b0 || sram_gwen !== 1'b0 || sram_wen !== 144'h0 || sram_d !== 144'h0 ||
             sram_a !== 12'(i) || req_rdy !== 1'b0 || init_done !== 1'b0 || rsp_vld !== 1'b0)
            err++;
      end
      chk("init_writes", 144'(nwr), 144'd4096);
      chk("init_seq_err", 144'(err), 144'd0);
      req_vld = 1'b0;
      @(negedge clk); #1;
      chk("init_done", {143'h0, init_done}, 144'h1);
      chk("run_rdy", {143'h0, req_rdy}, 144'h1);
      chk("run_idle_cen", {143'h0, sram_cen}, 144'h1);
      @(negedge clk);
   endtask

   logic        exp_rdy5 [10] = '{1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0};
   logic        exp_vld5 [10] = '{1'b0, 1'b0, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 1'b0};
   logic [7:0]  exp_dat5 [10] = '{8'h0, 8'h0, 8'h0, 8'h0, 8'h0, 8'h0, 8'h1, 8'h2, 8'h3, 8'h0};
   logic        vld5     [10] = '{1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0};
   logic [11:0] adr5     [10] = '{12'd0, 12'd1, 12'd2, 12'd2, 12'd2, 12'd2, 12'd3, 12'd0, 12'd0, 12'd0};
   logic        rrdy5    [10] = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1};

   initial begin
      rst_n = 1'b0; req_vld = 1'b0; req_wr = 1'b0; req_addr = '0;
      req_wdata = '0; req_wmask = '0; rsp_rdy = 1'b1;

      // Reset values
      repeat (3) @(negedge clk);
      #1;
      chk("rst_rsp_vld", {143'h0, rsp_vld}, 144'h0);
      chk("rst_rsp_data", rsp_data, 144'h0);
      chk("rst_init_done", {143'h0, init_done}, 144'h0);
      chk("rst_req_rdy", {143'h0, req_rdy}, 144'h0);
      chk("rst_cen", {143'h0, sram_cen}, 144'h1);
      chk("rst_gwen", {143'h0, sram_gwen}, 144'h1);
      chk("rst_wen", sram_wen, ONES);
      @(negedge clk);

      init_run();
      read_chk("rd_abc_zero", 12'hABC, 144'h0);

      // Write pin behaviour in the accept cycle, then read back
      req_vld = 1'b1; req_wr = 1'b1; req_addr = 12'h123; req_wdata = PAT5A; req_wmask = ONES;
      #1;
      chk("wr_cen", {143'h0, sram_cen}, 144'h0);
      chk("wr_gwen", {143'h0, sram_gwen}, 144'h0);
      chk("wr_wen", sram_wen, 144'h0);
      chk("wr_a", 144'(sram_a), 144'h123);
      chk("wr_d", sram_d, PAT5A);
      @(posedge clk); #1 req_vld = 1'b0;
      @(negedge clk);
      req_vld = 1'b1; req_wr = 1'b0; req_addr = 12'h123;
      #1;
      chk("rd_cen", {143'h0, sram_cen}, 144'h0);
      chk("rd_gwen", {143'h0, sram_gwen}, 144'h1);
      chk("rd_wen", sram_wen, ONES);
      req_vld = 1'b0;
      #1 chk("idle_cen", {143'h0, sram_cen}, 144'h1);
      @(negedge clk);
      read_chk("rd_123", 12'h123, PAT5A);

      // Partial mask write
      send(1'b1, 12'h7FF, ONES, ONES);
      req_vld = 1'b1; req_wr = 1'b1; req_addr = 12'h7FF; req_wdata = '0;
      req_wmask = {72'h0, {72{1'b1}}};
      #1 chk("mask_wen", sram_wen, HALF);
      @(posedge clk); #1 req_vld = 1'b0;
      @(negedge clk);
      read_chk("rd_7ff_mask", 12'h7FF, HALF);

      // Preload 0..7 with value = address, then 8 back-to-back reads
      for (int i = 0; i < 8; i++) send(1'b1, 12'(i), 144'(i), ONES);
      req_wr = 1'b0;
      for (int c = 0; c < 10; c++) begin
         req_vld = (c < 8); req_addr = 12'(c);
         #1;
         if (c < 8) chk("b2b_rdy", {143'h0, req_rdy}, 144'h1);
         if (c >= 2) begin
            chk("b2b_vld", {143'h0, rsp_vld}, 144'h1);
            chk("b2b_data", rsp_data, 144'(c - 2));
         end
         @(negedge clk);
      end
      #1 chk("b2b_drained", {143'h0, rsp_vld}, 144'h0);
      @(negedge clk);

      // Backpressure: 4 reads offered with rsp_rdy low, then released
      req_wr = 1'b0;
      for (int c = 0; c < 10; c++) begin
         req_vld = vld5[c]; req_addr = adr5[c]; rsp_rdy = rrdy5[c];
         #1;
         if (c < 7) chk("bp_rdy", {143'h0, req_rdy}, {143'h0, exp_rdy5[c]});
         chk("bp_vld", {143'h0, rsp_vld}, {143'h0, exp_vld5[c]});
         if (exp_vld5[c]) chk("bp_data", rsp_data, 144'(exp_dat5[c]));
         @(negedge clk);
      end

      // Reset while two reads are outstanding
      rsp_rdy = 1'b0; req_wr = 1'b0;
      req_vld = 1'b1; req_addr = 12'd4;
      @(negedge clk);
      req_addr = 12'd5;
      @(negedge clk);
      req_vld = 1'b0;
      #1 chk("mid_vld_before", {143'h0, rsp_vld}, 144'h1);
      #1 rst_n = 1'b0;
      #1;
      chk("mid_rst_vld", {143'h0, rsp_vld}, 144'h0);
      chk("mid_rst_data", rsp_data, 144'h0);
      chk("mid_rst_rdy", {143'h0, req_rdy}, 144'h0);
      chk("mid_rst_done", {143'h0, init_done}, 144'h0);
      @(negedge clk);
      rsp_rdy = 1'b1;
      init_run();
      for (int c = 0; c < 3; c++) begin
         #1 chk("post_stale_vld", {143'h0, rsp_vld}, 144'h0);
         @(negedge clk);
      end
      read_chk("rd_5_refilled", 12'd5, 144'h0);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

endmodule
